// File: rtl/or_unit_arbiter.sv
// Round-robin arbiter that time-shares one external OR unit among N requesters.
// Each transaction walks IDLE -> DRIVE -> SAMPLE, one cycle per state.
module or_unit_arbiter #(
    parameter int N = 4,
    parameter int W = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] a,
    input  logic [N*W-1:0] b,
    output logic [N-1:0]   gnt,
    output logic [N-1:0]   done,
    output logic [W-1:0]   y_out,
    output logic           busy,
    output logic [W-1:0]   gate_a,
    output logic [W-1:0]   gate_b,
    input  logic [W-1:0]   gate_y,
    output logic [7:0]     xact_cnt
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SAMPLE
    } state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   last, last_nxt;
    logic [IW-1:0]   winner, winner_nxt;
    logic [IW-1:0]   pick;
    logic [N-1:0]    gnt_nxt, done_nxt;
    logic [W-1:0]    y_nxt, gate_a_nxt, gate_b_nxt;
    logic [7:0]      cnt_nxt;

    // Search starts just past the previous winner, so the last winner ranks lowest.
    always_comb begin
        int  idx;
        logic found;
        // NOTE: every combinational output gets a default first so no latch is inferred.
        pick  = last;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(last) + k) % N;
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = IW'(idx);
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        gnt_nxt    = gnt;
        done_nxt   = '0;
        y_nxt      = y_out;
        gate_a_nxt = gate_a;
        gate_b_nxt = gate_b;
        cnt_nxt    = xact_cnt;
        last_nxt   = last;
        winner_nxt = winner;
        unique case (state)
            IDLE: begin
                if (|req) begin
                    state_nxt     = DRIVE;
                    winner_nxt    = pick;
                    gnt_nxt       = '0;
                    gnt_nxt[pick] = 1'b1;
                    gate_a_nxt    = a[int'(pick)*W +: W];
                    gate_b_nxt    = b[int'(pick)*W +: W];
                end
            end
            DRIVE: begin
                // Operands have had a full cycle to settle through the OR unit.
                state_nxt = SAMPLE;
                done_nxt  = gnt;
                y_nxt     = gate_y;
                cnt_nxt   = xact_cnt + 8'd1;
                last_nxt  = winner;
            end
            SAMPLE: begin
                state_nxt  = IDLE;
                gnt_nxt    = '0;
                gate_a_nxt = '0;
                gate_b_nxt = '0;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gnt      <= '0;
            done     <= '0;
            y_out    <= '0;
            gate_a   <= '0;
            gate_b   <= '0;
            xact_cnt <= '0;
            last     <= IW'(N - 1);
            winner   <= '0;
        end else begin
            gnt      <= gnt_nxt;
            done     <= done_nxt;
            y_out    <= y_nxt;
            gate_a   <= gate_a_nxt;
            gate_b   <= gate_b_nxt;
            xact_cnt <= cnt_nxt;
            last     <= last_nxt;
            winner   <= winner_nxt;
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_or_unit_arbiter.sv
// Self-checking bench for or_unit_arbiter: directed scenarios plus randomized
// back-to-back traffic compared against a transaction-level reference model.
module tb_or_unit_arbiter;

    localparam int N = 4;
    localparam int W = 1;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] a, b;
    logic [N-1:0]   gnt, done;
    logic [W-1:0]   y_out, gate_a, gate_b, gate_y;
    logic           busy;
    logic [7:0]     xact_cnt;

    int errors = 0;
    int checks = 0;

    or_unit_arbiter #(.N(N), .W(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .a        (a),
        .b        (b),
        .gnt      (gnt),
        .done     (done),
        .y_out    (y_out),
        .busy     (busy),
        .gate_a   (gate_a),
        .gate_b   (gate_b),
        .gate_y   (gate_y),
        .xact_cnt (xact_cnt)
    );

    // The shared OR unit itself.
    assign gate_y = gate_a | gate_b;

    always #5 clk = ~clk;

    // Reference model: remaining cycles of the in-flight transaction (0 = free).
    int         m_left = 0;
    int         m_win  = 0;
    int         m_last = N - 1;
    int         m_cnt  = 0;
    logic [W-1:0] m_y  = '0;
    logic [W-1:0] m_ga = '0;
    logic [W-1:0] m_gb = '0;

    function automatic int rr_pick(input logic [N-1:0] r, input int prev);
        for (int k = 1; k <= N; k++) begin
            if (r[(prev + k) % N]) return (prev + k) % N;
        end
        return prev;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_left = 0;
            m_last = N - 1;
            m_cnt  = 0;
            m_y    = '0;
            m_ga   = '0;
            m_gb   = '0;
        end else if (m_left == 0) begin
            if (req != '0) begin
                m_win  = rr_pick(req, m_last);
                m_ga   = a[m_win*W +: W];
                m_gb   = b[m_win*W +: W];
                m_left = 2;
            end
        end else if (m_left == 2) begin
            m_left = 1;
            m_y    = m_ga | m_gb;
            m_cnt  = (m_cnt + 1) % 256;
            m_last = m_win;
        end else begin
            m_left = 0;
            m_ga   = '0;
            m_gb   = '0;
        end
    end

    function automatic logic [N-1:0] exp_gnt();
        logic [N-1:0] v = '0;
        if (m_left > 0) v[m_win] = 1'b1;
        return v;
    endfunction

    function automatic logic [N-1:0] exp_done();
        logic [N-1:0] v = '0;
        if (m_left == 1) v[m_win] = 1'b1;
        return v;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        a   = '0;
        b   = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Advances at least one cycle, then waits up to budget cycles for any done pulse.
    task automatic wait_done(input int budget, output logic [N-1:0] seen, output time t);
        seen = '0;
        t    = 0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (done != '0) begin
                seen = done;
                t    = $time;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = '1;
        a   = '1;
        b   = '1;
        repeat (3) @(negedge clk);
        checks++;
        if (gnt !== '0 || done !== '0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: gnt=%b done=%b busy=%b, want all 0", gnt, done, busy);
        end
        checks++;
        if (y_out !== '0 || gate_a !== '0 || gate_b !== '0 || xact_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_data: y=%h ga=%h gb=%h cnt=%0d, want all 0", y_out, gate_a, gate_b, xact_cnt);
        end
        req = '0;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0001;
        a   = 4'b0001;
        b   = 4'b0000;
        @(negedge clk);
        req = '0;
        checks++;
        if (gnt !== 4'b0001 || done !== 4'b0000 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_t1: gnt=%b done=%b busy=%b, want 0001 0000 1", gnt, done, busy);
        end
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0001 || done !== 4'b0001 || y_out !== 1'b1 || xact_cnt !== 8'd1) begin
            errors++;
            $display("FAIL single_t2: gnt=%b done=%b y=%b cnt=%0d, want 0001 0001 1 1", gnt, done, y_out, xact_cnt);
        end
        @(negedge clk);
        checks++;
        if (gnt !== '0 || done !== '0 || y_out !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL single_t3: gnt=%b done=%b y=%b busy=%b, want 0 0 1 0", gnt, done, y_out, busy);
        end
    endtask

    task automatic test_truth_table();
        logic [N-1:0] seen;
        time          t, t_prev;
        t_prev = 0;
        req = 4'b0100;
        for (int p = 0; p < 4; p++) begin
            a    = 4'($urandom_range(0, 15));
            b    = 4'($urandom_range(0, 15));
            a[2] = p[1];
            b[2] = p[0];
            wait_done(8, seen, t);
            checks++;
            if (seen !== 4'b0100 || y_out !== ((p != 0) ? 1'b1 : 1'b0)) begin
                errors++;
                $display("FAIL truth_%0d: done=%b y=%b, want 0100 %0d", p, seen, y_out, (p != 0));
            end
            if (p > 0) begin
                checks++;
                if (t - t_prev != 30) begin
                    errors++;
                    $display("FAIL truth_gap_%0d: gap=%0t, want 30", p, t - t_prev);
                end
            end
            t_prev = t;
        end
        req = '0;
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        logic [N-1:0] seen, expv;
        time          t, t_prev;
        t_prev = 0;
        rst = 1'b1;
        req = 4'b1111;
        a   = 4'b0101;
        b   = 4'b0011;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            wait_done(8, seen, t);
            expv = '0;
            expv[k % N] = 1'b1;
            checks++;
            if (seen !== expv) begin
                errors++;
                $display("FAIL rr_order_%0d: done=%b, want %b", k, seen, expv);
            end
            if (k > 0) begin
                checks++;
                if (t - t_prev != 30) begin
                    errors++;
                    $display("FAIL rr_gap_%0d: gap=%0t, want 30", k, t - t_prev);
                end
            end
            t_prev = t;
        end
        req = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_priority_drop();
        logic [N-1:0] seen;
        time          t;
        do_reset();
        req = 4'b0010;
        wait_done(8, seen, t);
        req = '0;
        @(negedge clk);
        req = 4'b1010;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b1000) begin
            errors++;
            $display("FAIL prio_gnt3: gnt=%b, want 1000", gnt);
        end
        req = 4'b0010;
        @(negedge clk);
        checks++;
        if (done !== 4'b1000) begin
            errors++;
            $display("FAIL prio_drop_done: done=%b, want 1000", done);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (gnt !== 4'b0010) begin
            errors++;
            $display("FAIL prio_gnt1: gnt=%b, want 0010", gnt);
        end
        wait_done(8, seen, t);
        checks++;
        if (seen !== 4'b0010) begin
            errors++;
            $display("FAIL prio_done1: done=%b, want 0010", seen);
        end
        req = '0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] seen;
        time          t;
        do_reset();
        req = 4'b0010;
        a   = 4'b0010;
        b   = 4'b0000;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0010) begin
            errors++;
            $display("FAIL abort_pre: gnt=%b, want 0010", gnt);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (gnt !== '0 || done !== '0 || y_out !== '0 || xact_cnt !== 8'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_state: gnt=%b done=%b y=%b cnt=%0d busy=%b, want 0s", gnt, done, y_out, xact_cnt, busy);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0010 || done !== '0) begin
            errors++;
            $display("FAIL abort_regrant: gnt=%b done=%b, want 0010 0000", gnt, done);
        end
        wait_done(8, seen, t);
        checks++;
        if (seen !== 4'b0010 || y_out !== 1'b1 || xact_cnt !== 8'd1) begin
            errors++;
            $display("FAIL abort_done: done=%b y=%b cnt=%0d, want 0010 1 1", seen, y_out, xact_cnt);
        end
        req = '0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int ntx = 0;
        do_reset();
        for (int c = 0; c < 1200 && ntx < 256; c++) begin
            req = 4'($urandom_range(1, 15));
            a   = 4'($urandom_range(0, 15));
            b   = 4'($urandom_range(0, 15));
            @(negedge clk);
            checks++;
            if (gnt !== exp_gnt() || !$onehot0(gnt)) begin
                errors++;
                $display("FAIL b2b_gnt c%0d: gnt=%b, want %b", c, gnt, exp_gnt());
            end
            checks++;
            if (done !== exp_done() || !$onehot0(done)) begin
                errors++;
                $display("FAIL b2b_done c%0d: done=%b, want %b", c, done, exp_done());
            end
            checks++;
            if (gate_a !== m_ga || gate_b !== m_gb || y_out !== m_y) begin
                errors++;
                $display("FAIL b2b_data c%0d: ga=%b gb=%b y=%b, want %b %b %b", c, gate_a, gate_b, y_out, m_ga, m_gb, m_y);
            end
            checks++;
            if (busy !== (m_left > 0) || xact_cnt !== 8'(m_cnt)) begin
                errors++;
                $display("FAIL b2b_stat c%0d: busy=%b cnt=%0d, want %b %0d", c, busy, xact_cnt, (m_left > 0), m_cnt);
            end
            if (done != '0) ntx++;
        end
        checks++;
        if (ntx != 256 || xact_cnt !== 8'd0) begin
            errors++;
            $display("FAIL b2b_wrap: transactions=%0d cnt=%0d, want 256 0", ntx, xact_cnt);
        end
        req = '0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        req = '0;
        a   = '0;
        b   = '0;
        test_reset();
        test_single();
        test_truth_table();
        test_round_robin();
        test_priority_drop();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/or_unit_arbiter.md
OR_UNIT_ARBITER -- requirements
Module: or_unit_arbiter

Interface
REQ-001 Parameter N, default 4, meaning number of requesters sharing one OR-gate unit (N >= 2).
REQ-002 Parameter W, default 1, meaning operand/result width of the shared OR unit.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 req  input  N  per-requester request; bit i = requester i wants one OR evaluation.
REQ-006 a  input  N*W  requester operands A; slice [i*W +: W] belongs to requester i.
REQ-007 b  input  N*W  requester operands B; same slicing as a.
REQ-008 gnt  output  N  one-hot grant; bit i high while requester i owns the OR unit.
REQ-009 done  output  N  one-hot, one-cycle pulse; result for requester i valid on y_out.
REQ-010 y_out  output  W  registered OR result of the current or most recent transaction.
REQ-011 busy  output  1  high whenever the state is not IDLE.
REQ-012 gate_a  output  W  registered A operand driven to the shared OR unit.
REQ-013 gate_b  output  W  registered B operand driven to the shared OR unit.
REQ-014 gate_y  input  W  combinational result returned by the shared OR unit.
REQ-015 xact_cnt  output  8  count of completed transactions, wraps 255 -> 0.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, DRIVE, SAMPLE.
REQ-017 IDLE, req == 0: SHALL stay in IDLE; gnt, done, gate_a and gate_b hold 0.
REQ-018 IDLE, req != 0: SHALL select the winner by round-robin, searching from (last+1) mod N upward with wrap; SHALL register a/b slices of the winner into gate_a/gate_b, set gnt to one-hot winner, go to DRIVE.
REQ-019 DRIVE: SHALL hold gnt, gate_a and gate_b unchanged for one cycle (OR-unit settle time), then go to SAMPLE.
REQ-020 SAMPLE: SHALL capture gate_y into y_out, pulse done[winner] for this cycle only, set last = winner, increment xact_cnt, deassert gnt, clear gate_a/gate_b, go to IDLE.
REQ-021 Latency: req sampled in IDLE at cycle t -> gnt high at t+1 and t+2; done at t+2 with y_out valid; next grant earliest at t+3.
REQ-022 Throughput: at most one transaction per 3 cycles; gnt and done SHALL never have more than one bit set.
REQ-023 Operands SHALL be captured only in IDLE; changes on a/b or req during DRIVE/SAMPLE SHALL not affect the current transaction.
REQ-024 A requester dropping req after grant SHALL not abort the transaction; done still pulses.
REQ-025 A req bit still high in the cycle after done SHALL be treated as a new request and arbitrated with round-robin priority (lowest priority for the last winner).
REQ-026 Simultaneous requests SHALL be served in round-robin order with no requester starved: any continuously asserted req is granted within N transactions.
REQ-027 y_out SHALL hold its value between SAMPLE cycles.
REQ-028 xact_cnt SHALL wrap from 255 to 0 without any other effect.

Reset
REQ-029 While rst is high at a clock edge: state SHALL become IDLE; gnt, done, y_out, gate_a, gate_b, busy, xact_cnt SHALL become 0; last SHALL become N-1, so requester 0 has highest priority first.
REQ-030 Reset asserted in DRIVE or SAMPLE SHALL discard the in-flight transaction with no done pulse and no xact_cnt increment.

Verification
REQ-031 After reset, req=4'b0001, a0=1, b0=0 -> gnt=0001 at t+1..t+2, done=0001 at t+2, y_out=1, xact_cnt=1.
REQ-032 Exhaustive truth table via requester 2: (a,b) = 00,01,10,11 in sequence -> y_out = 0,1,1,1, each done 3 cycles apart.
REQ-033 req=4'b1111 held continuously from reset -> grant order 0,1,2,3,0,1 with done pulses every 3 cycles.
REQ-034 req=4'b1010 with last=1 -> requester 3 granted before requester 1; req[3] dropped during DRIVE -> done[3] still pulses.
REQ-035 rst asserted during DRIVE of requester 1 -> next cycle gnt=0, done never pulses, y_out=0, xact_cnt unchanged at 0; after release, req=0010 -> requester 1 granted normally.
REQ-036 256 back-to-back transactions -> xact_cnt returns to 0; gnt/done one-hot checked every cycle.
